// File: rtl/cpu_pkg.sv
// Shared definitions for the interrupt controller: FSM state encoding,
// default sizing and the NMI vector constant.
package cpu_pkg;

   localparam int N_SRC_DEFAULT = 8;
   localparam int VEC_W_DEFAULT = 3;

   // Processor handshake FSM: IDLE waits for work, REQ drives INT or NMI,
   // ACK waits for the processor to drop INA.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ACK  = 2'd2
   } state_t;

   // The NMI vector is the vector MSB alone; the low bits are left zero.
   function automatic logic [31:0] nmi_vec(input int vec_w);
      return 32'd1 << vec_w;
   endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// Signal bundle between the interrupt controller and its environment:
// device requests, mask register write port, processor handshake and
// debug visibility of the FSM state and pending flags.
//
// Handshake: the controller raises INT (or NMI) with int_vec stable while in
// REQ; the processor answers with a level INA=1 held until INT/NMI drop,
// then lowers INA; only after INA is seen low can a new request be raised.
interface interrupt_controller_if
   import cpu_pkg::*;
#(
   parameter int N_SRC = N_SRC_DEFAULT,
   parameter int VEC_W = VEC_W_DEFAULT
);
   logic [N_SRC-1:0] irq;
   logic             nmi_src;
   logic             mask_we;
   logic [N_SRC:0]   mask_wdata;
   logic             INA;
   logic             INT;
   logic             NMI;
   logic             INTD;
   logic [VEC_W:0]   int_vec;
   state_t           fsm_state;
   logic [N_SRC-1:0] pending;
   logic             nmi_pend;

   // Environment side: devices, software register writes and the processor.
   modport master (
      output irq, nmi_src, mask_we, mask_wdata, INA,
      input  INT, NMI, INTD, int_vec, fsm_state, pending, nmi_pend
   );

   // Controller side.
   modport slave (
      input  irq, nmi_src, mask_we, mask_wdata, INA,
      output INT, NMI, INTD, int_vec, fsm_state, pending, nmi_pend
   );
endinterface

// File: rtl/prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the index
// of the lowest set request.
module prio_enc #(
   parameter int N_SRC = 8,
   parameter int VEC_W = 3
) (
   input  logic [N_SRC-1:0] req,
   output logic             valid,
   output logic [VEC_W-1:0] idx
);

   // Scan from the top down so the lowest set index is the last to land.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            valid = 1'b1;
            idx   = VEC_W'(i);
         end
      end
   end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: edge-detects device and NMI requests into pending
// flags, arbitrates NMI first then lowest unmasked index, and runs a
// three-state handshake with the processor over INT/NMI/INA.
module interrupt_controller
   import cpu_pkg::*;
#(
   parameter int N_SRC = N_SRC_DEFAULT,
   parameter int VEC_W = VEC_W_DEFAULT
) (
   input logic                  clk,
   input logic                  rst_n,
   interrupt_controller_if.slave bus
);

   localparam logic [VEC_W:0] NMI_VEC = (VEC_W + 1)'(nmi_vec(VEC_W));

   logic [N_SRC-1:0] irq_s;
   logic [N_SRC-1:0] irq_q;
   logic [N_SRC-1:0] irq_edge;
   logic             nmi_s;
   logic             nmi_q;
   logic             nmi_edge;

   logic [N_SRC-1:0] pending;
   logic [N_SRC-1:0] pending_d;
   logic [N_SRC-1:0] clr_vec;
   logic             nmi_pend;
   logic             nmi_pend_d;

   logic [N_SRC:0]   mask_reg;
   logic             intd;

   state_t           state;
   state_t           state_d;
   logic [VEC_W:0]   int_vec_r;
   logic [VEC_W:0]   int_vec_d;
   logic             grant_nmi;
   logic             grant_nmi_d;
   logic             ack_take;
   logic             int_o;
   logic             nmi_o;

   logic             enc_valid;
   logic [VEC_W-1:0] enc_idx;

   assign intd = mask_reg[N_SRC];

   // Sample the requests, then keep the previous sample; an edge is the
   // sampled copy high while the older copy is still low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_s <= '0;
         irq_q <= '0;
         nmi_s <= 1'b0;
         nmi_q <= 1'b0;
      end else begin
         irq_s <= bus.irq;
         irq_q <= irq_s;
         nmi_s <= bus.nmi_src;
         nmi_q <= nmi_s;
      end
   end

   assign irq_edge = irq_s & ~irq_q;
   assign nmi_edge = nmi_s & ~nmi_q;

   // Mask/disable register; comes out of reset fully masked and disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask_reg <= '1;
      end else if (bus.mask_we) begin
         mask_reg <= bus.mask_wdata;
      end
   end

   // Arbitration among pending sources that are not masked.
   prio_enc #(
      .N_SRC (N_SRC),
      .VEC_W (VEC_W)
   ) u_prio_enc (
      .req   (pending & ~mask_reg[N_SRC-1:0]),
      .valid (enc_valid),
      .idx   (enc_idx)
   );

   // Handshake next state, grant latching and processor-facing outputs.
   always_comb begin
      state_d     = state;
      int_vec_d   = int_vec_r;
      grant_nmi_d = grant_nmi;
      ack_take    = 1'b0;
      int_o       = 1'b0;
      nmi_o       = 1'b0;
      case (state)
         IDLE: begin
            if (nmi_pend) begin
               state_d     = REQ;
               grant_nmi_d = 1'b1;
               int_vec_d   = NMI_VEC;
            end else if (!intd && enc_valid) begin
               state_d     = REQ;
               grant_nmi_d = 1'b0;
               int_vec_d   = {1'b0, enc_idx};
            end
         end
         REQ: begin
            nmi_o = grant_nmi;
            int_o = !grant_nmi;
            if (bus.INA) begin
               state_d  = ACK;
               ack_take = 1'b1;
            end
         end
         ACK: begin
            if (!bus.INA) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Pending update: the acknowledged source clears, a fresh edge on the
   // same bit in the same cycle still sets it so the event is not lost.
   always_comb begin
      clr_vec = '0;
      if (ack_take && !grant_nmi) begin
         clr_vec[int_vec_r[VEC_W-1:0]] = 1'b1;
      end
      pending_d  = (pending & ~clr_vec) | irq_edge;
      nmi_pend_d = (nmi_pend & ~(ack_take & grant_nmi)) | nmi_edge;
   end

   // FSM state, latched grant and pending flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         int_vec_r <= '0;
         grant_nmi <= 1'b0;
         pending   <= '0;
         nmi_pend  <= 1'b0;
      end else begin
         state     <= state_d;
         int_vec_r <= int_vec_d;
         grant_nmi <= grant_nmi_d;
         pending   <= pending_d;
         nmi_pend  <= nmi_pend_d;
      end
   end

   assign bus.INT       = int_o;
   assign bus.NMI       = nmi_o;
   assign bus.INTD      = intd;
   assign bus.int_vec   = int_vec_r;
   assign bus.fsm_state = state;
   assign bus.pending   = pending;
   assign bus.nmi_pend  = nmi_pend;

endmodule
